// File: rtl/sn74ls195a_pkg.sv
// rtl/sn74ls195a_pkg.sv - shared state encoding and helpers for the shift sequencer
package sn74ls195a_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/SN74LS195Agates.sv
// rtl/SN74LS195Agates.sv - behavioural model of a parallel-access shift register with J/K-bar serial input
module SN74LS195Agates #(
    parameter int LENGTH = 4
) (
    input  logic              CP,
    input  logic              MR,
    input  logic              PE,
    input  logic              J,
    input  logic              K,
    input  logic [LENGTH-1:0] P,
    output logic [LENGTH-1:0] Q,
    output logic              Q3
);

    logic q0_next;

    // K is the active-low K-bar input: J=0,K=1 holds Q0, J=1,K=0 toggles it.
    assign q0_next = (J & ~Q[0]) | (K & Q[0]);
    assign Q3      = Q[LENGTH-1];

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            Q <= '0;
        end else if (!PE) begin
            Q <= P;
        end else begin
            Q <= {Q[LENGTH-2:0], q0_next};
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with a single priority pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_sel
);

    logic ptr;

    // The pointer only matters on a tie; a lone requester always wins.
    always_comb begin
        gnt_sel = req[1];
        if (req == 2'b11) begin
            gnt_sel = ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~gnt_sel;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - arbitrates two requesters and drives a load/shift-out cycle on an external shift register
module shift_sequencer
    import sn74ls195a_pkg::*;
#(
    parameter int   LENGTH = 4,
    parameter logic FILL   = 1'b0
) (
    input  logic                CP,
    input  logic                MR,
    input  logic [1:0]          req,
    input  logic [2*LENGTH-1:0] wdata,
    input  logic                Q3,
    output logic                PE,
    output logic                J,
    output logic                K,
    output logic [LENGTH-1:0]   P,
    output logic [1:0]          gnt,
    output logic                busy,
    output logic                done,
    output logic                owner,
    output logic [LENGTH-1:0]   rdata
);

    localparam int            CW       = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

    if (LENGTH < 2) begin : g_length_check
        $error("shift_sequencer: LENGTH must be at least 2");
    end

    seq_state_t    state;
    seq_state_t    state_nx;
    logic [CW-1:0] cnt;
    logic          sel;
    logic          accept;

    assign accept = (state == IDLE) && (|req);

    rr_arb2 u_arb (
        .clk     (CP),
        .rst_n   (MR),
        .req     (req),
        .advance (accept),
        .gnt_sel (sel)
    );

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        PE       = 1'b1;
        J        = 1'b0;
        K        = 1'b1;
        gnt      = 2'b00;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                PE       = 1'b0;
                gnt      = onehot2(owner);
                state_nx = SHIFT;
            end
            SHIFT: begin
                J = FILL;
                K = FILL;
                if (cnt == CNT_LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Q3 already carries the register MSB before each shift edge, so the word arrives MSB first.
    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            cnt   <= '0;
            P     <= '0;
            owner <= 1'b0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= sel;
                        P     <= sel ? wdata[2*LENGTH-1:LENGTH] : wdata[LENGTH-1:0];
                    end
                end
                LOAD: begin
                    cnt <= '0;
                end
                SHIFT: begin
                    rdata <= {rdata[LENGTH-2:0], Q3};
                    cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter LENGTH, default 4: width of the controlled SN74LS195A-style shift register.
REQ-002 SHALL have parameter FILL, default 1'b0: value shifted into Q0 during shift cycles.
REQ-003 SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- CP  input  1: clock; all state changes on rising edge.
- MR  input  1: master reset, asynchronous, active-low.
- req  input  2: per-requester request levels, held until granted.
- wdata  input  2*LENGTH: requester words; bits [LENGTH-1:0] belong to requester 0, [2*LENGTH-1:LENGTH] to requester 1.
- Q3  input  1: serial output of the controlled shift register.
- PE  output  1: parallel-enable to register, active-low (0 = load).
- J, K  output  1 each: serial-input controls to register.
- P  output  LENGTH: parallel-load word to register.
- gnt  output  2: one-hot grant pulse.
- busy  output  1: high in any state other than IDLE.
- done  output  1: one-cycle completion pulse.
- owner  output  1: index of requester whose transfer is in flight or just completed.
- rdata  output  LENGTH: word captured from Q3.

Function
REQ-004 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-005 IDLE: if any req is high, SHALL choose a winner round-robin, latch its wdata slice into P, set owner and go to LOAD; otherwise SHALL stay in IDLE.
REQ-006 Arbitration SHALL use a priority pointer (reset 0) that favours the pointed requester when both request and toggles to the non-winner after every grant.
REQ-007 LOAD lasts exactly one cycle: PE=0, gnt[owner]=1; the next state SHALL be SHIFT with the bit counter cleared.
REQ-008 SHIFT lasts exactly LENGTH cycles: PE=1, J=FILL, K=FILL; each cycle SHALL shift Q3 into rdata LSB-first-in (rdata <= {rdata[LENGTH-2:0], Q3}).
REQ-009 After LENGTH samples, rdata SHALL equal the loaded word, MSB first out; the counter wraps and the state goes to DONE.
REQ-010 DONE lasts one cycle with done=1 and rdata stable, then SHALL return to IDLE; rdata SHALL hold its value until the next SHIFT.
REQ-011 The latency from LOAD entry to done SHALL be exactly LENGTH+1 cycles; the minimum request-to-request spacing SHALL be LENGTH+3 cycles.
REQ-012 req changes during LOAD, SHIFT or DONE SHALL be ignored; wdata SHALL be sampled only on the IDLE->LOAD transition.
REQ-013 Outside LOAD, PE SHALL be 1; outside SHIFT, J=0 and K=1 (hold-compatible, Q0 retains under shift only).
REQ-014 The bit counter width SHALL be $clog2(LENGTH+1); LENGTH SHALL be at least 2.

Reset
REQ-015 MR=0 SHALL immediately force state=IDLE, pointer=0, counter=0, PE=1, J=0, K=1, P=0, gnt=0, busy=0, done=0, owner=0, rdata=0.
REQ-016 Reset mid-transfer SHALL abort with no done pulse; the first grant after release follows REQ-006 from pointer 0.

Structure
REQ-017 The state encoding (2-bit enum IDLE/LOAD/SHIFT/DONE) SHALL live in shared package sn74ls195a_pkg.
REQ-018 The two-input round-robin arbiter SHALL be a sub-module rr_arb2 (req[1:0], advance -> gnt_sel, pointer state).

Verification
REQ-019 The bench SHALL instantiate SN74LS195Agates (LENGTH=4) on the same CP/MR with Q3 looped back, and cover:
- req=01, wdata[3:0]=4'b1011 -> gnt=01 for 1 cycle; done 5 cycles after LOAD; rdata=4'b1011, owner=0.
- req=11 held, wdata=8'hA5 -> first grant to req0 (rdata=4'h5), second grant to req1 (rdata=4'hA), pointer alternates.
- req1 asserted during SHIFT of req0 -> no gnt until IDLE; req1 LOAD begins exactly LENGTH+3 cycles after req0 LOAD.
- MR pulsed low on the 2nd SHIFT cycle -> all outputs at reset values at once, no done; a new req=10 is granted to req1 normally.
- FILL=1, wdata=4'b0000 -> after done, register Q=4'b1111, rdata=4'b0000.
